nvdla_cacc_group_ctrl: RTL

NVDLA_CACC_GROUP_CTRL -- requirements
Module: nvdla_cacc_group_ctrl

---
 rtl/nvdla_cacc_group_ctrl_pkg.sv | 23 ++
 rtl/nvdla_cacc_group_ctrl_if.sv | 23 ++
 rtl/nvdla_cacc_group_ctrl_fsm.sv | 37 +++
 rtl/nvdla_cacc_group_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/nvdla_cacc_group_ctrl_pkg.sv
// Shared types and constants for the CACC dual-group launch controller:
// group-state encoding, CSB register offsets and the layer cycle counter width.
package nvdla_cacc_ctrl_pkg;

  localparam int CNT_W = 32;

  localparam logic [11:0] REG_STATUS      = 12'h000;
  localparam logic [11:0] REG_POINTER     = 12'h004;
  localparam logic [11:0] REG_LAST_CYCLES = 12'h008;
  localparam logic [11:0] REG_ERR         = 12'h00C;

  typedef enum logic [1:0] {
    GRP_IDLE    = 2'd0,
    GRP_PENDING = 2'd1,
    GRP_RUNNING = 2'd2
  } grp_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/nvdla_cacc_group_ctrl_if.sv
// CSB register-access bundle between the register host and the group controller.
interface nvdla_cacc_group_ctrl_if;
  // No valid/ready here: reg_wr_en qualifies reg_offset/reg_wr_data for exactly
  // the cycle it is high, and reg_rd_data is a combinational function of reg_offset.
  logic        reg_wr_en;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;

  modport master (
    output reg_wr_en,
    output reg_offset,
    output reg_wr_data,
    input  reg_rd_data
  );

  modport slave (
    input  reg_wr_en,
    input  reg_offset,
    input  reg_wr_data,
    output reg_rd_data
  );
endinterface

// File: rtl/nvdla_cacc_group_ctrl_fsm.sv
// Per-group op_en state machine: IDLE -> PENDING on an enabling trigger,
// PENDING -> RUNNING on launch, RUNNING -> IDLE on done.
module nvdla_cacc_group_fsm
  import nvdla_cacc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       wr_data,
  input  logic       launch,
  input  logic       done,
  output grp_state_e state,
  output logic       trig_err
);

  grp_state_e state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= GRP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trig_err  = 1'b0;
    case (state)
      GRP_IDLE:    if (trigger && wr_data) state_nxt = GRP_PENDING;
      GRP_PENDING: if (launch)             state_nxt = GRP_RUNNING;
      GRP_RUNNING: if (done)               state_nxt = GRP_IDLE;
      default:                             state_nxt = GRP_IDLE;
    endcase
    // An enabling write to a busy group is dropped; a done in the same cycle
    // still counts the group as busy.
    if (trigger && wr_data && (state != GRP_IDLE)) trig_err = 1'b1;
  end

endmodule

// File: rtl/nvdla_cacc_group_ctrl.sv
// CACC ping-pong group controller: launches the two dual register groups strictly
// in consumer order, times each layer, and raises done/error status.
module nvdla_cacc_group_ctrl
  import nvdla_cacc_ctrl_pkg::*;
(
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  nvdla_cacc_group_ctrl_if.slave        csb,
  input  logic                          op_en_trigger_d0,
  input  logic                          op_en_trigger_d1,
  input  logic                          op_en_wr_data,
  input  logic                          dp2reg_done,
  output logic                          op_en_d0,
  output logic                          op_en_d1,
  output logic                          reg2dp_op_en,
  output logic                          reg2dp_group_sel,
  output logic [1:0]                    done_intr,
  output logic                          err_flag
);

  grp_state_e       state0;
  grp_state_e       state1;
  grp_state_e       cons_state;
  logic             consumer;
  logic             any_running;
  logic             launch_ok;
  logic             done_ok;
  logic             done_err;
  logic             trig_err0;
  logic             trig_err1;
  logic             err_set;
  logic             err_clr;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] last_layer_cycles;

  assign any_running = (state0 == GRP_RUNNING) || (state1 == GRP_RUNNING);
  assign cons_state  = consumer ? state1 : state0;
  assign launch_ok   = !any_running && (cons_state == GRP_PENDING);
  assign done_ok     = dp2reg_done && (cons_state == GRP_RUNNING);
  assign done_err    = dp2reg_done && !done_ok;

  nvdla_cacc_group_fsm u_grp0 (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .trigger  (op_en_trigger_d0),
    .wr_data  (op_en_wr_data),
    .launch   (launch_ok && !consumer),
    .done     (done_ok && !consumer),
    .state    (state0),
    .trig_err (trig_err0)
  );

  nvdla_cacc_group_fsm u_grp1 (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .trigger  (op_en_trigger_d1),
    .wr_data  (op_en_wr_data),
    .launch   (launch_ok && consumer),
    .done     (done_ok && consumer),
    .state    (state1),
    .trig_err (trig_err1)
  );

  assign op_en_d0         = (state0 != GRP_IDLE);
  assign op_en_d1         = (state1 != GRP_IDLE);
  assign reg2dp_op_en     = (cons_state == GRP_RUNNING);
  assign reg2dp_group_sel = consumer;

  assign err_set = trig_err0 || trig_err1 || done_err;
  assign err_clr = csb.reg_wr_en && (csb.reg_offset == REG_ERR);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      consumer  <= 1'b0;
      done_intr <= 2'b00;
      err_flag  <= 1'b0;
    end else begin
      if (done_ok) consumer <= ~consumer;
      done_intr <= done_ok ? (consumer ? 2'b10 : 2'b01) : 2'b00;
      if (err_set)      err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
    end
  end

  // The captured length includes the done cycle itself, so it equals the number
  // of cycles reg2dp_op_en was high for the layer.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cycle_cnt         <= '0;
      last_layer_cycles <= '0;
    end else if (done_ok) begin
      last_layer_cycles <= sat_inc(cycle_cnt);
      cycle_cnt         <= '0;
    end else if (any_running) begin
      cycle_cnt <= sat_inc(cycle_cnt);
    end
  end

  always_comb begin
    csb.reg_rd_data = 32'h0;
    case (csb.reg_offset)
      REG_STATUS:      csb.reg_rd_data = {14'b0, state1, 14'b0, state0};
      REG_POINTER:     csb.reg_rd_data = {15'b0, consumer, 16'b0};
      REG_LAST_CYCLES: csb.reg_rd_data = last_layer_cycles;
      REG_ERR:         csb.reg_rd_data = {31'b0, err_flag};
      default:         csb.reg_rd_data = 32'h0;
    endcase
  end

endmodule
